afifo_rd_packer: RTL

- Read-side consumer for the async FIFO, running entirely in the FIFO read-clock domain.
- Pops DATA_WIDTH words through the FIFO read port (empty/rinc/rdata) and packs PACK consecutive words into one wide word, little-endian.
- Presents each packed word on a valid/ready stream toward the system side.
- A flush input emits a partially filled word, so JTAG transfers that do not fill a whole word are not stranded.

---
 rtl/afifo_rd_packer_if.sv | 34 +++
 rtl/afifo_rd_packer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/afifo_rd_packer_if.sv
// rtl/afifo_rd_packer_if.sv - FIFO read port plus packed-word stream bundle for afifo_rd_packer
//
// Purpose: carries the async FIFO read port (fifo_empty/fifo_rdata/fifo_rinc),
// the flush request and the packed output stream (out_valid/out_ready/out_data/out_count)
// together with the busy status.
// Modports:
//   master - packer side: drives fifo_rinc, out_valid, out_data, out_count, busy
//   slave  - environment side: drives fifo_empty, fifo_rdata, flush, out_ready
interface afifo_rd_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
);
    localparam int CW = $clog2(PACK + 1);

    logic                       fifo_empty;
    logic [DATA_WIDTH-1:0]      fifo_rdata;
    logic                       fifo_rinc;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_WIDTH*PACK-1:0] out_data;
    logic [CW-1:0]              out_count;
    logic                       busy;

    modport master (
        input  fifo_empty, fifo_rdata, flush, out_ready,
        output fifo_rinc, out_valid, out_data, out_count, busy
    );

    modport slave (
        output fifo_empty, fifo_rdata, flush, out_ready,
        input  fifo_rinc, out_valid, out_data, out_count, busy
    );
endinterface

// File: rtl/afifo_rd_packer.sv
// rtl/afifo_rd_packer.sv - packs PACK FIFO words into one little-endian wide word on a valid/ready stream
//
// Purpose: read-clock-domain consumer of the async FIFO. Pops words while
// filling, emits a full word after PACK pops, or a partial word on flush.
// Ports:
//   clk  - FIFO read clock
//   rst  - synchronous active-high reset
//   bus  - afifo_rd_packer_if.master (FIFO read port, flush, output stream, busy)
module afifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic              clk,
    input  logic              rst,
    afifo_rd_packer_if.master bus
);
    localparam int IW = $clog2(PACK);
    localparam int CW = $clog2(PACK + 1);
    localparam int OW = DATA_WIDTH * PACK;

    typedef enum logic {FILL = 1'b0, OUT = 1'b1} state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   idx;
    logic [OW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic            last_lane;
    logic            flush_go;
    logic            pop;
    logic            accept;

    assign last_lane = (idx == IW'(PACK - 1));
    // A flush with nothing accumulated is dropped; it never suppresses nothing-to-emit cycles into OUT.
    assign flush_go  = (state == FILL) && bus.flush && (idx != '0);
    // Flush wins over pop so the head word remains queued for the next packed word.
    assign pop       = (state == FILL) && !rst && !bus.fifo_empty && !bus.flush;
    assign accept    = (state == OUT) && bus.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (flush_go) begin
                    state_next = OUT;
                end else if (pop && last_lane) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (accept) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Datapath: lane index, accumulator and lane count of the pending word
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            acc <= '0;
            cnt <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (flush_go) begin
                        cnt <= CW'(idx);
                    end else if (pop) begin
                        acc[idx*DATA_WIDTH +: DATA_WIDTH] <= bus.fifo_rdata;
                        if (last_lane) begin
                            // idx is left at PACK-1 and cleared on acceptance, never wrapped
                            cnt <= CW'(PACK);
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (accept) begin
                        idx <= '0;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                default: begin
                    idx <= '0;
                    acc <= '0;
                    cnt <= '0;
                end
            endcase
        end
    end

    // Outputs; the partially filled accumulator is not exposed while filling
    always_comb begin
        bus.fifo_rinc = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_count = '0;
        bus.busy      = (state == OUT) || (idx != '0);
        if (state == OUT) begin
            bus.out_valid = 1'b1;
            bus.out_data  = acc;
            bus.out_count = cnt;
        end else begin
            bus.fifo_rinc = pop;
        end
    end
endmodule
